// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_t : fetch sequencer states (IDLE/REQ/WAIT/DROP)
//   fetch_entry_t : one fetch-buffer entry, {pc, instr}
//   PC_INCR       : byte distance between consecutive instruction words
//   word_align    : clears the byte-offset bits of an address
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_INCR = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Fetch buffer: synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, pop     write / read strobes (ignored when full / empty)
//   flush         empties the FIFO; has priority over push and pop
//   push_data     entry to write
//   head          entry at the read pointer (register-sourced, no comb
//                 path from push_data)
//   full, empty   occupancy flags
//   count         current occupancy
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  push_data,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end. Owns the program counter, issues word reads
// over a req/gnt/rvalid handshake (one request outstanding at most),
// buffers {pc, instr} pairs and hands them to decode over valid/ready.
// Redirects from EX flush buffered and in-flight work.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   imem_req/addr                 read request and word address
//   imem_gnt/rvalid/rdata         memory accept, read data valid, data
//   redirect_valid/pc             taken branch/jump and its target
//   id_valid/instr/pc, id_ready   fetch-buffer head to decode
//   fetch_pc                      address of next request to be issued
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt (FIFO pushes) and
// perf_stall_cnt (cycles with id_valid & ~id_ready); both wrap at 2^32 and
// ignore redirects.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no request pending; waiting for buffer space
// REQ   | imem_req high with imem_addr = fetch_pc, waiting for gnt
// WAIT  | request granted; rdata will be pushed on rvalid
// DROP  | request granted before a redirect; rdata discarded on rvalid
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  output logic [31:0] fetch_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int              CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_M1 = CW'(FIFO_DEPTH - 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   tag_q, tag_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          space_after_push;

  assign id_valid  = ~fifo_empty;
  assign fifo_pop  = id_valid & id_ready;
  assign id_pc     = head_entry.pc;
  assign id_instr  = head_entry.instr;
  assign imem_addr = pc_q;
  assign fetch_pc  = pc_q;

  assign push_entry.pc    = tag_q;
  assign push_entry.instr = imem_rdata;

  // After this cycle's push, is there still a free slot? A simultaneous pop
  // frees one, so the next request can be issued without a bubble.
  assign space_after_push = fifo_pop | (fifo_count < DEPTH_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tag_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tag_d      = tag_q;
    imem_req   = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Nothing outstanding here, so space means simply "not full".
        if (!fifo_full) state_d = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          tag_d   = pc_q;
          pc_d    = pc_q + PC_INCR;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          fifo_push = 1'b1;
          state_d   = space_after_push ? REQ : IDLE;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      pc_d      = word_align(redirect_pc);
      fifo_push = 1'b0;
      unique case (state_q)
        // Already waiting out a stale response: only the target moves.
        DROP: ;
        // If the response lands in the redirect cycle itself, nothing is
        // left in flight, so there is nothing to drop.
        WAIT: begin
          fifo_flush = 1'b1;
          state_d    = imem_rvalid ? REQ : DROP;
        end
        REQ: begin
          fifo_flush = 1'b1;
          state_d    = imem_gnt ? DROP : REQ;
        end
        default: begin
          fifo_flush = 1'b1;
          state_d    = REQ;
        end
      endcase
    end
  end

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .push_data (push_entry),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fifo_push)             perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_valid && !id_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;
  logic [31:0] fetch_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready),
    .fetch_pc       (fetch_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory contents: any fixed function of the address will do.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2008_0001;
  endfunction

  // ---------------- memory model ----------------
  int          gnt_pct   = 100;
  int          fixed_lat = 0;    // < 0 selects random latency 0..max_lat
  int          max_lat   = 2;
  bit          pend      = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_dly  = 0;
  int          gnt_count = 0;
  logic [31:0] last_gnt_addr = '0;

  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      if (imem_req && imem_gnt) begin
        check("one_outstanding", {31'd0, pend}, 32'd0);
        pend          = 1'b1;
        pend_addr     = imem_addr;
        gnt_count++;
        last_gnt_addr = imem_addr;
        pend_dly      = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, max_lat));
      end
      #1;
      imem_rvalid = 1'b0;
      if (pend) begin
        if (pend_dly == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end else begin
          pend_dly--;
        end
      end
      imem_gnt = !rst && imem_req && (int'($urandom_range(0, 99)) < gnt_pct);
    end
  end

  // ---------------- reference model / scoreboard ----------------
  // Decode must see a sequential word stream starting at the last reset or
  // redirect target; the queue holds the upcoming expected addresses.
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;
  logic [31:0] exp_pc;

  function automatic void refill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(start + 32'(4 * i));
    exp_tail = start + 32'd12;
  endfunction

  always @(negedge clk) begin
    if (!rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_empty: got transfer pc %h expected none", id_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        check("id_pc", id_pc, exp_pc);
        check("id_instr", id_instr, mem_word(exp_pc));
        exp_tail = exp_tail + 32'd4;
        exp_q.push_back(exp_tail);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    refill(RPC);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    @(posedge clk);
    refill(t & ~32'h3);
    #1;
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    check("fetch_pc_redirect", fetch_pc, t & ~32'h3);
  endtask

  task automatic wait_grant(input string name);
    int g0;
    g0 = gnt_count;
    for (int i = 0; i < 50 && gnt_count == g0; i++) step(1);
    if (gnt_count == g0) begin
      checks++;
      $display("FAIL %s: got no grant expected one within 50 cycles", name);
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50 && !id_valid; i++) step(1);
    check(name, {31'd0, id_valid}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef IF_PERF_CNT_EN
    logic [31:0] s0;
`endif
    logic [31:0] tgt;
    // Reset state and first fetch.
    step(1);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_fetch_pc", fetch_pc, RPC);
    gnt_pct = 100; fixed_lat = 0; id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !imem_req; i++) step(1);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    wait_valid("first_valid");
    check("first_pc", id_pc, 32'h0);
    check("first_instr", id_instr, 32'h2008_0001);

    // Decode stalled: exactly FIFO_DEPTH fetches, then requests stop.
    step(20);
    check("stall_grants", gnt_count, DEPTH);
    check("stall_last_addr", last_gnt_addr, 32'h4);
    check("stall_req_low", {31'd0, imem_req}, 32'd0);
`ifdef IF_PERF_CNT_EN
    s0 = perf_stall_cnt;
    step(10);
    check("perf_stall", perf_stall_cnt - s0, 32'd10);
    check("perf_fetch", perf_fetch_cnt, DEPTH);
`endif
    id_ready = 1'b1;
    step(10);

    // Redirect while a response is outstanding: that response is dropped.
    id_ready = 1'b0; fixed_lat = 2;
    do_reset();
    wait_grant("pre_drop_grant");
    do_redirect(32'h0000_0102);
    check("drop_flushed", {31'd0, id_valid}, 32'd0);
    wait_grant("post_drop_grant");
    check("post_drop_addr", last_gnt_addr, 32'h100);
    wait_valid("post_drop_valid");
    check("post_drop_pc", id_pc, 32'h100);
    check("post_drop_instr", id_instr, mem_word(32'h100));

    // Address wrap at the top of memory.
    fixed_lat = 0;
    do_redirect(32'hFFFF_FFFF);
    wait_grant("wrap_grant0");
    check("wrap_addr0", last_gnt_addr, 32'hFFFF_FFFC);
    wait_grant("wrap_grant1");
    check("wrap_addr1", last_gnt_addr, 32'h0);
    wait_valid("wrap_valid");

    // Redirect in the same cycle as a decode transfer.
    id_ready = 1'b1;
    do_redirect(32'h0000_0200);
    id_ready = 1'b0;
    wait_valid("redir_xfer_valid");
    check("redir_xfer_pc", id_pc, 32'h200);
    id_ready = 1'b1;
    step(8);

    // Reset while in WAIT with one buffered entry; late rvalid ignored.
    id_ready = 1'b0; fixed_lat = 3;
    do_reset();
    wait_valid("rst_wait_valid");
    wait_grant("rst_wait_grant");
    rst = 1'b1;
    gnt_pct = 0;
    #1;
    check("async_rst_req", {31'd0, imem_req}, 32'd0);
    check("async_rst_valid", {31'd0, id_valid}, 32'd0);
    step(2);
    refill(RPC);
    rst = 1'b0;
    check("rst_fetch_pc2", fetch_pc, RPC);
    for (int i = 0; i < 20 && pend; i++) step(1);
    step(2);
    check("late_rvalid_ignored", {31'd0, id_valid}, 32'd0);
    gnt_pct = 100;
    wait_grant("rst_regrant");
    check("rst_regrant_addr", last_gnt_addr, RPC);
    id_ready = 1'b1;
    step(8);

    // Randomized traffic: variable grant/latency, decode backpressure,
    // redirects (some near the wrap point).
    gnt_pct = 70; fixed_lat = -1; max_lat = 2;
    for (int n = 0; n < 3000; n++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else tgt = $urandom;
        do_redirect(tgt);
      end else begin
        step(1);
      end
    end
    id_ready = 1'b1;
    step(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
